// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin two-port sequencer for a 4096x8 synchronous ROM with byte/word reads
//   clk, reset (async, active-high)
//   req_n/addr_n/word_n : port n request, byte address, size (0 byte, 1 little-endian word)
//   ack_n/valid_n/data_n : accept pulse, result pulse, zero-extended read data (held)
//   rom_address/rom_data : registered ROM address out, ROM data in (one-cycle latency)
module rom_arbiter #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_0,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic                  word_0,
    output logic                  ack_0,
    output logic                  valid_0,
    output logic [15:0]           data_0,
    input  logic                  req_1,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic                  word_1,
    output logic                  ack_1,
    output logic                  valid_1,
    output logic [15:0]           data_1,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [7:0]            rom_data
);
    typedef enum logic [1:0] {IDLE, LO_WAIT, HI_WAIT} state_t;
    state_t state;
    logic owner, is_word, rr_last, second;
    logic [7:0] low_byte;
    logic pick;
    logic [15:0] result;
    // on a tie the port that did not win last time is chosen
    assign pick = (req_0 && req_1) ? ~rr_last : req_1;
    assign result = is_word ? {rom_data, low_byte} : {8'h00, rom_data};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            is_word     <= 1'b0;
            rr_last     <= 1'b1;
            second      <= 1'b0;
            low_byte    <= 8'h00;
            rom_address <= '0;
            ack_0       <= 1'b0;
            ack_1       <= 1'b0;
            valid_0     <= 1'b0;
            valid_1     <= 1'b0;
            data_0      <= 16'h0000;
            data_1      <= 16'h0000;
        end else begin
            ack_0   <= 1'b0;
            ack_1   <= 1'b0;
            valid_0 <= 1'b0;
            valid_1 <= 1'b0;
            case (state)
                IDLE: if (req_0 || req_1) begin
                    rom_address <= pick ? addr_1 : addr_0;
                    is_word     <= pick ? word_1 : word_0;
                    owner       <= pick;
                    rr_last     <= pick;
                    ack_0       <= ~pick;
                    ack_1       <= pick;
                    second      <= 1'b0;
                    state       <= LO_WAIT;
                end
                LO_WAIT: begin
                    // high byte address goes out while the low byte is being read
                    if (is_word) rom_address <= rom_address + ADDR_WIDTH'(1);
                    state <= HI_WAIT;
                end
                HI_WAIT: if (is_word && !second) begin
                    low_byte <= rom_data;
                    second   <= 1'b1;
                end else begin
                    if (owner) data_1 <= result;
                    else data_0 <= result;
                    valid_0 <= ~owner;
                    valid_1 <= owner;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed bench with a transaction-level scoreboard checked every cycle
module tb_rom_arbiter;
    localparam int AW = 12;
    logic clk = 1'b0, reset = 1'b1;
    logic req_0 = 1'b0, word_0 = 1'b0, req_1 = 1'b0, word_1 = 1'b0;
    logic [AW-1:0] addr_0 = '0, addr_1 = '0;
    logic ack_0, valid_0, ack_1, valid_1;
    logic [15:0] data_0, data_1;
    logic [AW-1:0] rom_address;
    logic [7:0] rom_data = 8'h00;
    logic [7:0] mem [0:4095];
    int cyc = 0, n_cmp = 0, n_bad = 0;

    rom_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .addr_0(addr_0), .word_0(word_0),
        .ack_0(ack_0), .valid_0(valid_0), .data_0(data_0),
        .req_1(req_1), .addr_1(addr_1), .word_1(word_1),
        .ack_1(ack_1), .valid_1(valid_1), .data_1(data_1),
        .rom_address(rom_address), .rom_data(rom_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= mem[rom_address];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // scoreboard: per-cycle event slots filled when a grant is predicted
    bit s_ack0 [16], s_ack1 [16], s_v0 [16], s_v1 [16], s_as [16];
    logic [AW-1:0] s_addr [16];
    logic [15:0] s_data [16];
    logic [AW-1:0] m_addr;
    logic [15:0] m_d0, m_d1;
    bit m_last;
    int idle_from;

    always @(negedge clk) begin : compare
        int i, lat;
        bit n, w;
        logic [AW-1:0] a, a1;
        i = cyc % 16;
        if (reset) begin
            for (int j = 0; j < 16; j++) begin
                s_ack0[j] = 0; s_ack1[j] = 0; s_v0[j] = 0; s_v1[j] = 0; s_as[j] = 0;
            end
            m_addr = '0; m_d0 = '0; m_d1 = '0; m_last = 1; idle_from = cyc;
        end else begin
            if (s_as[i]) m_addr = s_addr[i];
            if (s_v0[i]) m_d0 = s_data[i];
            if (s_v1[i]) m_d1 = s_data[i];
        end
        check("ack_0", 32'(ack_0), 32'(s_ack0[i]));
        check("ack_1", 32'(ack_1), 32'(s_ack1[i]));
        check("valid_0", 32'(valid_0), 32'(s_v0[i]));
        check("valid_1", 32'(valid_1), 32'(s_v1[i]));
        check("data_0", 32'(data_0), 32'(m_d0));
        check("data_1", 32'(data_1), 32'(m_d1));
        check("rom_address", 32'(rom_address), 32'(m_addr));
        s_ack0[i] = 0; s_ack1[i] = 0; s_v0[i] = 0; s_v1[i] = 0; s_as[i] = 0;
        if (!reset && cyc >= idle_from && (req_0 || req_1)) begin
            n = (req_0 && req_1) ? !m_last : req_1;
            a = n ? addr_1 : addr_0;
            w = n ? word_1 : word_0;
            a1 = a + 12'd1;
            m_last = n;
            lat = w ? 4 : 3;
            idle_from = cyc + lat;
            if (n) s_ack1[(cyc + 1) % 16] = 1; else s_ack0[(cyc + 1) % 16] = 1;
            s_as[(cyc + 1) % 16] = 1; s_addr[(cyc + 1) % 16] = a;
            if (w) begin s_as[(cyc + 2) % 16] = 1; s_addr[(cyc + 2) % 16] = a1; end
            if (n) s_v1[(cyc + lat) % 16] = 1; else s_v0[(cyc + lat) % 16] = 1;
            s_data[(cyc + lat) % 16] = w ? {mem[a1], mem[a]} : {8'h00, mem[a]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        tick();
    endtask

    int q[$];
    int ac[$];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
        mem[12'h010] = 8'hA5;
        mem[12'h100] = 8'h34; mem[12'h101] = 8'h12;
        mem[12'hFFF] = 8'hCD; mem[12'h000] = 8'hAB;
        mem[12'h200] = 8'h77; mem[12'h201] = 8'h66;
        repeat (3) @(posedge clk);
        do_reset();
        check("reset_data_0", 32'(data_0), 32'h0);
        // byte read, port 0
        req_0 = 1; addr_0 = 12'h010; word_0 = 0;
        tick();
        check("t1_ack_0", 32'(ack_0), 32'h1);
        check("t1_addr", 32'(rom_address), 32'h010);
        req_0 = 0;
        tick(); tick();
        check("t1_valid_0", 32'(valid_0), 32'h1);
        check("t1_data_0", 32'(data_0), 32'h00A5);
        check("t1_data_1", 32'(data_1), 32'h0);
        tick();
        // word read, port 1
        req_1 = 1; addr_1 = 12'h100; word_1 = 1;
        tick();
        check("t2_ack_1", 32'(ack_1), 32'h1);
        req_1 = 0;
        tick();
        check("t2_addr_hi", 32'(rom_address), 32'h101);
        tick(); tick();
        check("t2_valid_1", 32'(valid_1), 32'h1);
        check("t2_data_1", 32'(data_1), 32'h1234);
        check("t2_data_0", 32'(data_0), 32'h00A5);
        tick();
        // word read wrapping the address space
        req_0 = 1; addr_0 = 12'hFFF; word_0 = 1;
        tick();
        check("t3_addr_lo", 32'(rom_address), 32'hFFF);
        req_0 = 0;
        tick();
        check("t3_addr_wrap", 32'(rom_address), 32'h000);
        tick(); tick();
        check("t3_data_0", 32'(data_0), 32'hABCD);
        tick();
        // both ports continuously requesting after reset
        do_reset();
        req_0 = 1; addr_0 = 12'h020; word_0 = 0;
        req_1 = 1; addr_1 = 12'h021; word_1 = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (ack_0) q.push_back(0);
            if (ack_1) q.push_back(1);
        end
        req_0 = 0; req_1 = 0;
        check("t4_grant_count", 32'(q.size()), 32'd4);
        for (int k = 0; k < q.size() && k < 4; k++) check("t4_grant_order", 32'(q[k]), 32'(k % 2));
        repeat (4) tick();
        // port 0 back-to-back byte reads
        req_0 = 1; addr_0 = 12'h030; word_0 = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (ack_0) begin ac.push_back(cyc); addr_0 = addr_0 + 12'd1; end
        end
        req_0 = 0;
        check("t5_ack_count", 32'(ac.size()), 32'd4);
        for (int k = 1; k < ac.size(); k++) check("t5_ack_spacing", 32'(ac[k] - ac[k-1]), 32'd3);
        repeat (4) tick();
        // reset in the middle of a word read
        req_1 = 1; addr_1 = 12'h200; word_1 = 1;
        tick();
        check("t6_ack_1", 32'(ack_1), 32'h1);
        req_1 = 0;
        #1 reset = 1'b1;
        #1;
        check("t6_async_ack", 32'(ack_1), 32'h0);
        check("t6_async_addr", 32'(rom_address), 32'h0);
        check("t6_async_data_0", 32'(data_0), 32'h0);
        @(negedge clk);
        #1 reset = 1'b0;
        tick();
        repeat (4) tick();
        req_1 = 1; addr_1 = 12'h200; word_1 = 1;
        tick();
        req_1 = 0;
        tick(); tick(); tick();
        check("t6_valid_1", 32'(valid_1), 32'h1);
        check("t6_data_1", 32'(data_1), 32'h6677);
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
